bittest_rgb_checker: RTL and testbench

- Receive-side counterpart of the bit-walking bar generator, which drives 16 vertical bars, each lighting one RGB565 bit (MSB first).
- Sits on any parallel RGB565 + hs/vs/de bus, e.g. after a DVI/HDMI RX or in loopback ahead of DVI_TX_Top.
- Measures active geometry per frame and compares every active pixel against the expected bar pattern.
- Reports per-frame results plus sticky error status.

---
 rtl/bittest_rgb_checker.sv | 184 ++++++++++++++++++
 tb/tb_bittest_rgb_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bittest_rgb_checker.sv
// Receive-side checker for the 16-bar bit-walking RGB565 test pattern.
// Measures per-frame geometry, counts pixel mismatches and reports results.
module bittest_rgb_checker #(
    parameter int   H_ACTIVE = 1280,
    parameter int   V_ACTIVE = 720,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        rgb_clk,
    input  logic        rgb_rst_n,
    input  logic        rgb_vs,
    input  logic        rgb_hs,
    input  logic        rgb_de,
    input  logic [15:0] rgb_data,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] pix_err_cnt,
    output logic [11:0] meas_width,
    output logic [11:0] meas_height,
    output logic [15:0] frame_cnt,
    output logic        err_sticky
);

    localparam int              BAR_W    = H_ACTIVE / 16;
    localparam int              IW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [11:0]     H_ACT_W  = 12'(H_ACTIVE);
    localparam logic [11:0]     V_ACT_W  = 12'(V_ACTIVE);
    localparam logic [IW-1:0]   BAR_LAST = IW'(BAR_W - 1);

    typedef enum logic {WAIT_SYNC, RUN} state_t;

    typedef struct packed {
        logic        ok;
        logic [15:0] err;
        logic [11:0] width;
        logic [11:0] height;
    } result_t;

    state_t        state_q, state_d;
    logic          vs_prev_q, vs_prev_d;
    logic          line_open_q, line_open_d;
    logic [11:0]   x_q, x_d;
    logic [3:0]    bar_q, bar_d;
    logic [IW-1:0] inbar_q, inbar_d;
    logic [15:0]   err_q, err_d;
    logic [11:0]   lines_q, lines_d;
    logic [11:0]   last_q, last_d;
    logic          wbad_q, wbad_d;
    result_t       res_q, res_d;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          sticky_q, sticky_d;
    logic          done_q, done_d;

    logic          vs_edge, line_close, pix_bad, ok_n;
    logic [15:0]   exp_pix, err_n;
    logic [11:0]   x_inc, line_len, lines_n, last_n;
    logic          wbad_n;

    // hs carries no information for the checker
    logic unused_hs;
    assign unused_hs = rgb_hs;

    always_comb begin
        vs_edge    = (rgb_vs == VS_POL) && (vs_prev_q != VS_POL);
        exp_pix    = 16'h8000 >> bar_q;
        x_inc      = (x_q == 12'hFFF) ? x_q : x_q + 12'd1;
        pix_bad    = rgb_de && (x_q < H_ACT_W) && (rgb_data != exp_pix);
        // a vs edge with de still high closes the line including this pixel
        line_close = (line_open_q && !rgb_de) || (rgb_de && vs_edge);
        line_len   = rgb_de ? x_inc : x_q;

        err_n   = (pix_bad && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
        lines_n = (line_close && (lines_q != 12'hFFF)) ? lines_q + 12'd1 : lines_q;
        last_n  = line_close ? line_len : last_q;
        wbad_n  = wbad_q || (rgb_de && (x_q >= H_ACT_W))
                         || (line_close && (line_len != H_ACT_W));
        ok_n    = (err_n == 16'd0) && !wbad_n && (lines_n == V_ACT_W);

        state_d     = state_q;
        vs_prev_d   = rgb_vs;
        line_open_d = 1'b0;
        x_d         = 12'd0;
        bar_d       = 4'd0;
        inbar_d     = '0;
        err_d       = err_q;
        lines_d     = lines_q;
        last_d      = last_q;
        wbad_d      = wbad_q;
        res_d       = res_q;
        fcnt_d      = fcnt_q;
        sticky_d    = sticky_q;
        done_d      = 1'b0;

        case (state_q)
            WAIT_SYNC: begin
                if (vs_edge) begin
                    state_d = RUN;
                    err_d   = 16'd0;
                    lines_d = 12'd0;
                    last_d  = 12'd0;
                    wbad_d  = 1'b0;
                end
            end
            RUN: begin
                line_open_d = rgb_de && !vs_edge;
                if (rgb_de && !vs_edge) begin
                    x_d     = x_inc;
                    bar_d   = bar_q;
                    inbar_d = inbar_q;
                    if (x_q < H_ACT_W) begin
                        if (inbar_q == BAR_LAST) begin
                            inbar_d = '0;
                            bar_d   = bar_q + 4'd1;
                        end else begin
                            inbar_d = inbar_q + 1'b1;
                        end
                    end
                end

                if (vs_edge) begin
                    res_d.ok     = ok_n;
                    res_d.err    = err_n;
                    res_d.width  = last_n;
                    res_d.height = lines_n;
                    fcnt_d       = fcnt_q + 16'd1;
                    sticky_d     = sticky_q || !ok_n;
                    done_d       = 1'b1;
                    err_d        = 16'd0;
                    lines_d      = 12'd0;
                    last_d       = 12'd0;
                    wbad_d       = 1'b0;
                end else begin
                    err_d   = err_n;
                    lines_d = lines_n;
                    last_d  = last_n;
                    wbad_d  = wbad_n;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge rgb_clk) begin
        if (!rgb_rst_n) begin
            state_q     <= WAIT_SYNC;
            vs_prev_q   <= 1'b0;
            line_open_q <= 1'b0;
            x_q         <= 12'd0;
            bar_q       <= 4'd0;
            inbar_q     <= '0;
            err_q       <= 16'd0;
            lines_q     <= 12'd0;
            last_q      <= 12'd0;
            wbad_q      <= 1'b0;
            res_q       <= '0;
            fcnt_q      <= 16'd0;
            sticky_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_prev_q   <= vs_prev_d;
            line_open_q <= line_open_d;
            x_q         <= x_d;
            bar_q       <= bar_d;
            inbar_q     <= inbar_d;
            err_q       <= err_d;
            lines_q     <= lines_d;
            last_q      <= last_d;
            wbad_q      <= wbad_d;
            res_q       <= res_d;
            fcnt_q      <= fcnt_d;
            sticky_q    <= sticky_d;
            done_q      <= done_d;
        end
    end

    assign frame_done  = done_q;
    assign frame_ok    = res_q.ok;
    assign pix_err_cnt = res_q.err;
    assign meas_width  = res_q.width;
    assign meas_height = res_q.height;
    assign frame_cnt   = fcnt_q;
    assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_bittest_rgb_checker.sv
// Directed + randomized bench for bittest_rgb_checker against a frame-level model
// built from the bar rule (pixel = 8000 >> x/bar_width) and per-frame totals.
module tb_bittest_rgb_checker;

    localparam int H = 64;
    localparam int V = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs    = 1'b0;
    logic        hs    = 1'b0;
    logic        de    = 1'b0;
    logic [15:0] data  = 16'h0;

    logic        frame_done, frame_ok, err_sticky;
    logic [15:0] pix_err_cnt, frame_cnt;
    logic [11:0] meas_width, meas_height;

    bittest_rgb_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .VS_POL(1'b1)) dut (
        .rgb_clk     (clk),
        .rgb_rst_n   (rst_n),
        .rgb_vs      (vs),
        .rgb_hs      (hs),
        .rgb_de      (de),
        .rgb_data    (data),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .pix_err_cnt (pix_err_cnt),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .frame_cnt   (frame_cnt),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // frame-level model: raw (unsaturated) totals for the open frame
    int m_err, m_lines, m_last, m_cnt;
    bit m_wbad, m_sticky;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bar_pix(input int x);
        return (x < H) ? (16'h8000 >> (x / (H / 16))) : 16'h0000;
    endfunction

    task automatic clear_frame();
        m_err = 0; m_lines = 0; m_last = 0; m_wbad = 0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_done"},   32'(frame_done),  0);
        chk({pfx, "_ok"},     32'(frame_ok),    0);
        chk({pfx, "_pixerr"}, 32'(pix_err_cnt), 0);
        chk({pfx, "_width"},  32'(meas_width),  0);
        chk({pfx, "_height"}, 32'(meas_height), 0);
        chk({pfx, "_fcnt"},   32'(frame_cnt),   0);
        chk({pfx, "_sticky"}, 32'(err_sticky),  0);
    endtask

    // called just after the edge on which the vs edge was sampled
    task automatic close(input bit expect_done);
        bit ok;
        if (expect_done) begin
            ok       = (m_err == 0) && !m_wbad && (m_lines == V);
            m_cnt    = (m_cnt + 1) & 32'hFFFF;
            m_sticky = m_sticky | !ok;
            chk("frame_done",  32'(frame_done),  1);
            chk("frame_ok",    32'(frame_ok),    32'(ok));
            chk("pix_err_cnt", 32'(pix_err_cnt), (m_err > 65535) ? 65535 : m_err);
            chk("meas_width",  32'(meas_width),  m_last);
            chk("meas_height", 32'(meas_height), (m_lines > 4095) ? 4095 : m_lines);
            chk("frame_cnt",   32'(frame_cnt),   m_cnt);
            chk("err_sticky",  32'(err_sticky),  32'(m_sticky));
        end else begin
            chk("no_frame_done", 32'(frame_done), 0);
        end
        clear_frame();
    endtask

    task automatic line(input int len, input int bad_x, input logic [15:0] bad_val,
                        input bit zero, input int hblank, input bit vs_last);
        logic [15:0] d;
        for (int x = 0; x < len; x++) begin
            d = zero ? 16'h0000 : ((x == bad_x) ? bad_val : bar_pix(x));
            if (x < H && d !== bar_pix(x)) m_err++;
            de = 1'b1; hs = 1'b0; data = d;
            if (vs_last && x == len - 1) vs = 1'b1;
            tick();
        end
        de = 1'b0; data = 16'h0; hs = 1'b1;
        m_lines++;
        m_last = len;
        if (len != H) m_wbad = 1'b1;
        if (vs_last) close(1'b1);
        repeat (hblank) tick();
        hs = 1'b0;
    endtask

    // vs held two cycles: one close only, results held afterwards
    task automatic vs_frame(input bit expect_done);
        vs = 1'b1;
        tick();
        close(expect_done);
        tick();
        chk("frame_done_single", 32'(frame_done), 0);
        vs = 1'b0;
        repeat (2) tick();
        chk("frame_cnt_hold", 32'(frame_cnt), m_cnt);
    endtask

    task automatic frame(input int nlines, input int bad_line, input int bad_x,
                         input logic [15:0] bad_val, input int last_len,
                         input bit zero, input int hb);
        int len, blank;
        repeat (3) tick();
        for (int l = 0; l < nlines; l++) begin
            len   = (l == nlines - 1) ? last_len : H;
            blank = (hb > 0) ? hb : 2 + int'($urandom_range(0, 3));
            line(len, (l == bad_line) ? bad_x : -1, bad_val, zero, blank, 1'b0);
        end
        vs_frame(1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_frame();
        m_cnt = 0; m_sticky = 0;

        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        vs_frame(1'b0);
        repeat (3) frame(V, -1, 0, 16'h0, H, 1'b0, 0);

        // single corrupted pixel on line 2, then a clean frame
        frame(V, 1, 10, 16'h0001, H, 1'b0, 0);
        frame(V, -1, 0, 16'h0, H, 1'b0, 0);

        // random single-pixel corruption
        for (int i = 0; i < 4; i++)
            frame(V, int'($urandom_range(0, V - 1)), int'($urandom_range(0, H - 1)),
                  16'($urandom), H, 1'b0, 0);

        // geometry errors: long last line, short frame, empty frame
        frame(V, -1, 0, 16'h0, H + 1, 1'b0, 0);
        frame(V - 1, -1, 0, 16'h0, H, 1'b0, 0);
        repeat (3) tick();
        vs_frame(1'b1);

        // vs edge coincident with the last pixel of the last line
        repeat (3) tick();
        for (int l = 0; l < V - 1; l++) line(H, -1, 16'h0, 1'b0, 2, 1'b0);
        line(H, -1, 16'h0, 1'b0, 2, 1'b1);
        chk("coincident_done_single", 32'(frame_done), 0);
        vs = 1'b0;
        repeat (2) tick();

        // one-cycle reset mid-frame
        line(H, -1, 16'h0, 1'b0, 2, 1'b0);
        line(H, 5, 16'hFFFF, 1'b0, 2, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_all_zero("midreset");
        rst_n = 1'b1;
        m_cnt = 0; m_sticky = 0;
        clear_frame();
        line(H, -1, 16'h0, 1'b0, 2, 1'b0);
        line(H, -1, 16'h0, 1'b0, 2, 1'b0);
        vs_frame(1'b0);
        frame(V, -1, 0, 16'h0, H, 1'b0, 0);

        // error counter saturation: 1100 all-zero lines
        frame(1100, -1, 0, 16'h0, H, 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
